// File: rtl/aurora_deserializer.sv
// Aurora RX deserializer: rebuilds a RECV_DATA_WIDTH message from one header beat plus
// NUMBER_PACKET payload beats. Optional macro ROUTER_ID_CHECK_EN enables payload router-id checking.
module aurora_deserializer #(
  parameter int NUMER_OF_LANE          = 1,
  parameter int AURORA_DATA_WIDTH      = 64 * NUMER_OF_LANE,
  parameter int RECV_DATA_WIDTH        = 1024,
  parameter int RECOGNIZE_HEADER_WIDTH = 1,
  parameter int RECOGNIZE_ROUTER_WIDTH = 2,
  parameter int HOST_PAYLOAD_WIDTH     = AURORA_DATA_WIDTH - 3,
  parameter int NUMBER_PACKET          = RECV_DATA_WIDTH / HOST_PAYLOAD_WIDTH + 1,
  parameter int ADDR_WIDTH             = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              axis_rx_tvalid,
  input  logic                              axis_rx_tlast,
  input  logic [AURORA_DATA_WIDTH-1:0]      axis_rx_tdata,
  output logic                              recv_data_valid,
  output logic [RECV_DATA_WIDTH-1:0]        v_data_recv,
  output logic [ADDR_WIDTH-1:0]             dst_addr_recv,
  output logic [1:0]                        TTL_recv,
  output logic [RECOGNIZE_ROUTER_WIDTH-1:0] router_id_recv,
  output logic                              frame_error
);

  localparam int FIELD_BASE = RECOGNIZE_HEADER_WIDTH + RECOGNIZE_ROUTER_WIDTH;
  localparam int ADDR_BASE  = FIELD_BASE + 2;
  localparam int LAST_W     = RECV_DATA_WIDTH - HOST_PAYLOAD_WIDTH * (NUMBER_PACKET - 1);
  localparam int CNT_W      = $clog2(NUMBER_PACKET + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUMBER_PACKET);
  localparam logic [CNT_W-1:0] FIRST_BEAT = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;

  state_t                              r_state, w_nextState;
  logic [CNT_W-1:0]                    r_frameCount, w_nextCount;
  logic [HOST_PAYLOAD_WIDTH-1:0]       r_chunk [NUMBER_PACKET-1];
  logic [ADDR_WIDTH-1:0]               r_dstAddr;
  logic [1:0]                          r_ttl;
  logic [RECOGNIZE_ROUTER_WIDTH-1:0]   r_routerId;
  logic                                w_isHeader, w_idMismatch, w_isLastBeat;
  logic                                w_latchHdr, w_store, w_commit, w_frameErr;
  logic [RECV_DATA_WIDTH-1:0]          w_message;
  logic [RECOGNIZE_ROUTER_WIDTH-1:0]   w_beatId;

  assign w_isHeader   = axis_rx_tdata[0];
  assign w_beatId     = axis_rx_tdata[RECOGNIZE_HEADER_WIDTH +: RECOGNIZE_ROUTER_WIDTH];
  assign w_isLastBeat = (r_frameCount == LAST_BEAT);

`ifdef ROUTER_ID_CHECK_EN
  assign w_idMismatch = (w_beatId != r_routerId);
`else
  assign w_idMismatch = 1'b0;
`endif

  // The final chunk is taken straight from the bus so the commit happens on the tlast beat itself.
  for (genvar g = 0; g < NUMBER_PACKET - 1; g++) begin : g_msg
    assign w_message[g*HOST_PAYLOAD_WIDTH +: HOST_PAYLOAD_WIDTH] = r_chunk[g];
  end
  assign w_message[RECV_DATA_WIDTH-1 -: LAST_W] = axis_rx_tdata[FIELD_BASE +: LAST_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_frameCount <= FIRST_BEAT;
    end else begin
      r_state      <= w_nextState;
      r_frameCount <= w_nextCount;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_frameCount;
    w_latchHdr  = 1'b0;
    w_store     = 1'b0;
    w_commit    = 1'b0;
    w_frameErr  = 1'b0;
    if (axis_rx_tvalid) begin
      unique case (r_state)
        IDLE, DROP: begin
          if (w_isHeader) begin
            w_latchHdr  = 1'b1;
            w_nextCount = FIRST_BEAT;
            w_nextState = PAYLOAD;
          end else if (r_state == IDLE) begin
            w_frameErr  = 1'b1;
            w_nextState = axis_rx_tlast ? IDLE : DROP;
          end else if (axis_rx_tlast) begin
            w_nextState = IDLE;
          end
        end
        PAYLOAD: begin
          if (w_isHeader) begin
            w_frameErr  = 1'b1;
            w_latchHdr  = 1'b1;
            w_nextCount = FIRST_BEAT;
          end else if (w_idMismatch) begin
            w_frameErr  = 1'b1;
            w_nextState = axis_rx_tlast ? IDLE : DROP;
          end else begin
            w_store     = 1'b1;
            w_nextCount = r_frameCount + FIRST_BEAT;
            if (axis_rx_tlast) begin
              w_nextState = IDLE;
              w_commit    = w_isLastBeat;
              w_frameErr  = !w_isLastBeat;
            end else if (w_isLastBeat) begin
              w_frameErr  = 1'b1;
              w_nextState = DROP;
            end
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Shadow registers collect the message; outputs only change on a clean commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      recv_data_valid <= 1'b0;
      frame_error     <= 1'b0;
      v_data_recv     <= '0;
      dst_addr_recv   <= '0;
      TTL_recv        <= '0;
      router_id_recv  <= '0;
      r_dstAddr       <= '0;
      r_ttl           <= '0;
      r_routerId      <= '0;
      for (int k = 0; k < NUMBER_PACKET - 1; k++) r_chunk[k] <= '0;
    end else begin
      recv_data_valid <= w_commit;
      frame_error     <= w_frameErr;
      if (w_latchHdr) begin
        r_dstAddr  <= axis_rx_tdata[ADDR_BASE +: ADDR_WIDTH];
        r_ttl      <= axis_rx_tdata[FIELD_BASE +: 2];
        r_routerId <= w_beatId;
      end
      if (w_store) begin
        for (int k = 0; k < NUMBER_PACKET - 1; k++)
          if (r_frameCount == CNT_W'(k + 1))
            r_chunk[k] <= axis_rx_tdata[FIELD_BASE +: HOST_PAYLOAD_WIDTH];
      end
      if (w_commit) begin
        v_data_recv    <= w_message;
        dst_addr_recv  <= r_dstAddr;
        TTL_recv       <= r_ttl;
        router_id_recv <= r_routerId;
      end
    end
  end

endmodule

// File: tb/tb_aurora_deserializer.sv
// Directed self-checking bench for aurora_deserializer: commit, gaps, early tlast,
// header restart, router-id check (ROUTER_ID_CHECK_EN), stray/overrun beats, reset, back-to-back.
module tb_aurora_deserializer;
  logic          clk = 1'b0;
  logic          rst_n;
  logic          tvalid, tlast;
  logic [63:0]   tdata;
  logic          recv_data_valid, frame_error;
  logic [1023:0] v_data_recv;
  logic [9:0]    dst_addr_recv;
  logic [1:0]    TTL_recv, router_id_recv;

  int errors = 0;
  int checks = 0;
  int validPulses = 0;
  int errPulses = 0;

  aurora_deserializer dut (
    .clk(clk), .rst_n(rst_n),
    .axis_rx_tvalid(tvalid), .axis_rx_tlast(tlast), .axis_rx_tdata(tdata),
    .recv_data_valid(recv_data_valid), .v_data_recv(v_data_recv),
    .dst_addr_recv(dst_addr_recv), .TTL_recv(TTL_recv),
    .router_id_recv(router_id_recv), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    validPulses += int'(recv_data_valid);
    errPulses   += int'(frame_error);
  end

  function automatic logic [60:0] chunk(input int seed, input int k);
    logic [63:0] x;
    x = {8'(k), 8'(seed), 16'(32'hA5C3 ^ (k * 37)),
         32'(32'h1357_9BDF + k * 32'h0101_0101 + seed * 32'h0011_0000)};
    return x[60:0];
  endfunction

  function automatic logic [63:0] hdr(input logic [9:0] dst, input logic [1:0] ttl, input logic [1:0] id);
    return {49'h1_2345_6789_ABCD, dst, ttl, id, 1'b1};
  endfunction

  function automatic logic [63:0] pay(input int seed, input int k, input logic [1:0] id);
    return {chunk(seed, k), id, 1'b0};
  endfunction

  function automatic logic [1023:0] expMsg(input int seed);
    logic [1023:0] m;
    logic [60:0]   c;
    m = '0;
    for (int k = 1; k <= 16; k++) m[61*(k-1) +: 61] = chunk(seed, k);
    c = chunk(seed, 17);
    m[1023:976] = c[47:0];
    return m;
  endfunction

  task automatic beat(input logic last, input logic [63:0] d);
    @(negedge clk);
    tvalid = 1'b1; tlast = last; tdata = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tvalid = 1'b0; tlast = 1'b0; tdata = {$urandom, $urandom};
    end
  endtask

  task automatic sendPayload(input int seed, input int from, input int to, input logic [1:0] id, input logic lastOnTo);
    for (int k = from; k <= to; k++) beat(lastOnTo && (k == to), pay(seed, k, id));
  endtask

  task automatic test_reset;
    rst_n = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0;
    idle(3);
    checks++; if (recv_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", recv_data_valid); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", frame_error); end
    checks++; if (v_data_recv !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", v_data_recv); end
    checks++; if ({dst_addr_recv, TTL_recv, router_id_recv} !== 14'h0) begin errors++; $display("FAIL reset_fields: got %h expected 0", {dst_addr_recv, TTL_recv, router_id_recv}); end
    rst_n = 1'b1;
  endtask

  task automatic test_full_message(input int seed, input logic withGap);
    int v0 = validPulses, e0 = errPulses;
    beat(1'b0, hdr(10'h155, 2'd2, 2'd1));
    sendPayload(seed, 1, 5, 2'd1, 1'b0);
    if (withGap) idle(3);
    sendPayload(seed, 6, 17, 2'd1, 1'b1);
    idle(1);
    checks++; if (recv_data_valid !== 1'b1) begin errors++; $display("FAIL full_valid_latency(gap=%0b): got %b expected 1", withGap, recv_data_valid); end
    checks++; if (v_data_recv !== expMsg(seed)) begin errors++; $display("FAIL full_data(gap=%0b): got %h expected %h", withGap, v_data_recv, expMsg(seed)); end
    checks++; if (dst_addr_recv !== 10'h155) begin errors++; $display("FAIL full_dst: got %h expected 155", dst_addr_recv); end
    checks++; if (TTL_recv !== 2'd2 || router_id_recv !== 2'd1) begin errors++; $display("FAIL full_ttl_id: got %0d/%0d expected 2/1", TTL_recv, router_id_recv); end
    idle(1);
    checks++; if (recv_data_valid !== 1'b0) begin errors++; $display("FAIL full_valid_width: got %b expected 0", recv_data_valid); end
    idle(2);
    checks++; if (validPulses - v0 != 1 || errPulses - e0 != 0) begin errors++; $display("FAIL full_pulses: got valid=%0d err=%0d expected 1/0", validPulses - v0, errPulses - e0); end
  endtask

  task automatic test_early_tlast;
    int v0 = validPulses, e0 = errPulses;
    beat(1'b0, hdr(10'h2AA, 2'd1, 2'd3));
    sendPayload(3, 1, 10, 2'd3, 1'b1);
    idle(1);
    checks++; if (frame_error !== 1'b1 || recv_data_valid !== 1'b0) begin errors++; $display("FAIL early_err: got err=%b valid=%b expected 1/0", frame_error, recv_data_valid); end
    idle(3);
    checks++; if (validPulses - v0 != 0 || errPulses - e0 != 1) begin errors++; $display("FAIL early_pulses: got valid=%0d err=%0d expected 0/1", validPulses - v0, errPulses - e0); end
    checks++; if (v_data_recv !== expMsg(2) || dst_addr_recv !== 10'h155 || TTL_recv !== 2'd2 || router_id_recv !== 2'd1) begin errors++; $display("FAIL early_hold: got dst=%h ttl=%0d id=%0d expected 155/2/1", dst_addr_recv, TTL_recv, router_id_recv); end
  endtask

  task automatic test_header_restart;
    int v0 = validPulses, e0 = errPulses;
    beat(1'b0, hdr(10'h2AA, 2'd1, 2'd3));
    sendPayload(3, 1, 8, 2'd3, 1'b0);
    beat(1'b0, hdr(10'h0F0, 2'd3, 2'd2));
    beat(1'b0, pay(4, 1, 2'd2));
    checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL restart_err: got %b expected 1", frame_error); end
    sendPayload(4, 2, 17, 2'd2, 1'b1);
    idle(1);
    checks++; if (recv_data_valid !== 1'b1 || v_data_recv !== expMsg(4)) begin errors++; $display("FAIL restart_data: valid=%b got %h expected %h", recv_data_valid, v_data_recv, expMsg(4)); end
    checks++; if (dst_addr_recv !== 10'h0F0 || TTL_recv !== 2'd3 || router_id_recv !== 2'd2) begin errors++; $display("FAIL restart_fields: got %h/%0d/%0d expected 0f0/3/2", dst_addr_recv, TTL_recv, router_id_recv); end
    idle(3);
    checks++; if (validPulses - v0 != 1 || errPulses - e0 != 1) begin errors++; $display("FAIL restart_pulses: got valid=%0d err=%0d expected 1/1", validPulses - v0, errPulses - e0); end
  endtask

  task automatic test_router_id;
    int v0 = validPulses, e0 = errPulses;
    beat(1'b0, hdr(10'h155, 2'd2, 2'd1));
    for (int k = 1; k <= 17; k++) begin
      beat(k == 17, pay(5, k, (k == 4) ? 2'd2 : 2'd1));
`ifdef ROUTER_ID_CHECK_EN
      if (k == 5) begin
        checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL rid_err: got %b expected 1", frame_error); end
      end
`else
      if (k == 5) begin
        checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL rid_noerr: got %b expected 0", frame_error); end
      end
`endif
    end
    idle(4);
`ifdef ROUTER_ID_CHECK_EN
    checks++; if (validPulses - v0 != 0 || errPulses - e0 != 1) begin errors++; $display("FAIL rid_pulses: got valid=%0d err=%0d expected 0/1", validPulses - v0, errPulses - e0); end
    checks++; if (v_data_recv !== expMsg(4) || dst_addr_recv !== 10'h0F0) begin errors++; $display("FAIL rid_hold: got dst=%h expected 0f0", dst_addr_recv); end
`else
    checks++; if (validPulses - v0 != 1 || errPulses - e0 != 0) begin errors++; $display("FAIL rid_pulses: got valid=%0d err=%0d expected 1/0", validPulses - v0, errPulses - e0); end
    checks++; if (v_data_recv !== expMsg(5) || dst_addr_recv !== 10'h155) begin errors++; $display("FAIL rid_data: got dst=%h expected 155", dst_addr_recv); end
`endif
  endtask

  task automatic test_stray_payload;
    int v0 = validPulses, e0 = errPulses;
    beat(1'b0, pay(6, 1, 2'd0));
    beat(1'b1, pay(6, 2, 2'd0));
    checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL stray_err: got %b expected 1", frame_error); end
    beat(1'b0, pay(6, 3, 2'd0));
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL stray_drop_quiet: got %b expected 0", frame_error); end
    beat(1'b0, hdr(10'h001, 2'd0, 2'd0));
    beat(1'b0, pay(6, 1, 2'd0));
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL stray_hdr_quiet: got %b expected 0", frame_error); end
    sendPayload(6, 2, 17, 2'd0, 1'b1);
    idle(1);
    checks++; if (recv_data_valid !== 1'b1 || v_data_recv !== expMsg(6) || dst_addr_recv !== 10'h001 || TTL_recv !== 2'd0 || router_id_recv !== 2'd0) begin errors++; $display("FAIL stray_commit: valid=%b dst=%h expected 1/001", recv_data_valid, dst_addr_recv); end
    idle(3);
    checks++; if (validPulses - v0 != 1 || errPulses - e0 != 2) begin errors++; $display("FAIL stray_pulses: got valid=%0d err=%0d expected 1/2", validPulses - v0, errPulses - e0); end
  endtask

  task automatic test_overrun;
    int v0 = validPulses, e0 = errPulses;
    beat(1'b0, hdr(10'h3FF, 2'd3, 2'd3));
    sendPayload(7, 1, 17, 2'd3, 1'b0);
    beat(1'b1, pay(7, 18, 2'd3));
    checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL overrun_err: got %b expected 1", frame_error); end
    idle(4);
    checks++; if (validPulses - v0 != 0 || errPulses - e0 != 1 || dst_addr_recv !== 10'h001) begin errors++; $display("FAIL overrun_pulses: got valid=%0d err=%0d dst=%h expected 0/1/001", validPulses - v0, errPulses - e0, dst_addr_recv); end
  endtask

  task automatic test_reset_mid;
    int v0 = validPulses, e0 = errPulses;
    beat(1'b0, hdr(10'h155, 2'd2, 2'd1));
    sendPayload(8, 1, 12, 2'd1, 1'b0);
    @(negedge clk); tvalid = 1'b0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    checks++; if (v_data_recv !== '0 || dst_addr_recv !== 10'h0) begin errors++; $display("FAIL rstmid_clear: got dst=%h expected 0", dst_addr_recv); end
    beat(1'b0, hdr(10'h2AA, 2'd1, 2'd3));
    sendPayload(9, 1, 17, 2'd3, 1'b1);
    idle(1);
    checks++; if (recv_data_valid !== 1'b1 || v_data_recv !== expMsg(9) || dst_addr_recv !== 10'h2AA || TTL_recv !== 2'd1 || router_id_recv !== 2'd3) begin errors++; $display("FAIL rstmid_commit: valid=%b dst=%h expected 1/2aa", recv_data_valid, dst_addr_recv); end
    idle(3);
    checks++; if (validPulses - v0 != 1 || errPulses - e0 != 0) begin errors++; $display("FAIL rstmid_pulses: got valid=%0d err=%0d expected 1/0", validPulses - v0, errPulses - e0); end
  endtask

  task automatic test_back_to_back;
    int v0 = validPulses, e0 = errPulses;
    beat(1'b0, hdr(10'h111, 2'd1, 2'd2));
    sendPayload(10, 1, 17, 2'd2, 1'b1);
    beat(1'b0, hdr(10'h222, 2'd2, 2'd1));
    checks++; if (recv_data_valid !== 1'b1 || v_data_recv !== expMsg(10) || dst_addr_recv !== 10'h111) begin errors++; $display("FAIL b2b_first: valid=%b dst=%h expected 1/111", recv_data_valid, dst_addr_recv); end
    beat(1'b0, pay(11, 1, 2'd1));
    checks++; if (recv_data_valid !== 1'b0) begin errors++; $display("FAIL b2b_width: got %b expected 0", recv_data_valid); end
    sendPayload(11, 2, 17, 2'd1, 1'b1);
    idle(1);
    checks++; if (recv_data_valid !== 1'b1 || v_data_recv !== expMsg(11) || dst_addr_recv !== 10'h222 || TTL_recv !== 2'd2 || router_id_recv !== 2'd1) begin errors++; $display("FAIL b2b_second: valid=%b dst=%h expected 1/222", recv_data_valid, dst_addr_recv); end
    idle(3);
    checks++; if (validPulses - v0 != 2 || errPulses - e0 != 0) begin errors++; $display("FAIL b2b_pulses: got valid=%0d err=%0d expected 2/0", validPulses - v0, errPulses - e0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full_message(1, 1'b0);
    test_full_message(2, 1'b1);
    test_early_tlast();
    test_header_restart();
    test_router_id();
    test_stray_payload();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aurora_deserializer.md
# aurora_deserializer

Receive-side counterpart of the router's Aurora transmit serializer. Consumes the AXI4-Stream beat sequence from the Aurora RX user interface: one header beat, then NUMBER_PACKET payload beats with tlast on the final one. Reassembles the RECV_DATA_WIDTH-bit message and presents it with its routing fields to the router core as a single-cycle valid pulse. Malformed sequences are dropped and flagged.

## Interface
- NUMER_OF_LANE, 1, Aurora lane count
- AURORA_DATA_WIDTH, 64*NUMER_OF_LANE, stream beat width
- RECV_DATA_WIDTH, 1024, reassembled message width
- RECOGNIZE_HEADER_WIDTH, 1, header/payload flag width (bit 0)
- RECOGNIZE_ROUTER_WIDTH, 2, router-id field width (bits [2:1])
- HOST_PAYLOAD_WIDTH, AURORA_DATA_WIDTH-3, payload bits per beat (61)
- NUMBER_PACKET, RECV_DATA_WIDTH/HOST_PAYLOAD_WIDTH+1, payload beats per message (17)
- ADDR_WIDTH, 10, destination address width
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- axis_rx_tvalid  in  1  beat valid; no backpressure, every valid beat is consumed
- axis_rx_tlast  in  1  last beat of message
- axis_rx_tdata  in  AURORA_DATA_WIDTH  beat data
- recv_data_valid  out  1  one-cycle pulse: message complete
- v_data_recv  out  RECV_DATA_WIDTH  reassembled message
- dst_addr_recv  out  ADDR_WIDTH  destination address from header
- TTL_recv  out  2  TTL from header
- router_id_recv  out  2  router id from header
- frame_error  out  1  one-cycle pulse: sequence dropped

## Operation
- Beat decode: tdata[0]=1 header, 0 payload; tdata[2:1] router id.
- Header: dst_addr=tdata[14:5], TTL=tdata[4:3], router_id=tdata[2:1]; tdata[63:15] ignored.
- Payload beat k (1..NUMBER_PACKET-1): tdata[63:3] -> message bits [61k-1 -: 61].
- Final beat k=NUMBER_PACKET: remaining RECV_DATA_WIDTH-61*(NUMBER_PACKET-1)=48 bits at tdata[50:3] -> message [1023:976]; tdata[63:51] ignored.
- States: IDLE, PAYLOAD, DROP. Counter frame_count, width $clog2(NUMBER_PACKET+1), value 1 on header accept.
- IDLE: header beat -> latch fields into shadow regs, frame_count=1, go PAYLOAD. Payload beat -> frame_error pulse, go DROP (stay IDLE if that beat has tlast).
- PAYLOAD: payload beat stores chunk, frame_count+1. tlast on beat NUMBER_PACKET -> commit, IDLE. tlast earlier -> frame_error, IDLE. Beat NUMBER_PACKET without tlast -> frame_error, DROP. Header beat -> frame_error, discard partial, restart with new header (stay PAYLOAD, frame_count=1).
- DROP: discard payload beats until tlast beat -> IDLE; header beat -> start new message as in IDLE, no further error.
- Commit: shadow data/fields copied to outputs, recv_data_valid pulsed. Outputs hold until next commit; a dropped message never alters them.
- tvalid low: no state change in any state (gaps allowed anywhere).

## Timing
- Reset values: recv_data_valid 0, frame_error 0, v_data_recv 0, dst_addr_recv 0, TTL_recv 0, router_id_recv 0; state IDLE, frame_count 1, shadow regs 0.
- Latency: recv_data_valid and new outputs visible cycle after the tlast beat is sampled.
- frame_error asserted cycle after the offending beat, one cycle wide.
- Back-to-back: header may arrive the cycle after a committing tlast beat; full rate 18 beats per message.
- Reset mid-message: partial data discarded, no valid/error pulse.

## Configuration
- ROUTER_ID_CHECK_EN defined: each payload beat's tdata[2:1] compared with latched header router id; mismatch -> frame_error, DROP (or IDLE if beat has tlast).
- Undefined: payload router-id bits ignored.

## Test plan
- Header dst=0x155,TTL=2,id=1 then 17 beats of pattern, tlast on 17th -> recv_data_valid one cycle after, v_data_recv matches, dst_addr_recv=0x155, TTL_recv=2, router_id_recv=1.
- Same message with tvalid low 3 cycles between beats 5/6 -> identical result, valid one cycle after tlast.
- tlast on beat 10 -> frame_error once, no recv_data_valid, outputs keep previous message.
- New header after beat 8 -> one frame_error, then the second full message commits correctly.
- ROUTER_ID_CHECK_EN, beat 4 id=2 vs header id=1 -> frame_error, remaining beats dropped through tlast, no valid; undefined -> commits normally.
- rst_n low one cycle after beat 12, then full message -> no pulse from the first, second commits.
